send_frames: RTL
================

# send_frames

Multi-frame UART transmitter, the transmit-side counterpart of the multi-frame receiver in the comms block. It accepts one `DATA_SIZE`-bit word on a single-cycle request and serialises it as `FRAMES` back-to-back UART frames, least-significant frame first. Each frame is start bit, `FRAME_SIZE` data bits LSB first, then one stop bit. It drives the host-link TX pin and reports busy/done status to the controller that issues words.

## Interface
- `CLK_BAUD_RATIO`, default 25: clock cycles per bit period; must be ≥ 1.
- `FRAME_SIZE`, default 8: data bits per frame; must be ≥ 1.
- `FRAMES`, default 2: frames per word; must be ≥ 1. Local `DATA_SIZE = FRAME_SIZE * FRAMES`.
- `clk_in`  input  1: the single clock; all logic on its rising edge.
- `rst_in`  input  1: reset, synchronous and active-high.
- `send_in`  input  1: request to transmit `data_in`; sampled only when `busy_out` is 0.
- `data_in`  input  `DATA_SIZE`: word to send; bits `[FRAME_SIZE-1:0]` form frame 0.
- `tx_out`  output  1: serial line, idle high.
- `busy_out`  output  1: high while a word is being transmitted.
- `done_out`  output  1: one-cycle pulse when the final stop bit completes.

## Operation
- State machine: IDLE, START, DATA, STOP.
- Internal counters:
  - Baud counter counts 0..`CLK_BAUD_RATIO`-1.
  - Bit index counts 0..`FRAME_SIZE`-1.
  - Frame index counts 0..`FRAMES`-1.
  - Each counter is sized with `$clog2(max+1)`, so it never overflows or wraps wrongly at parameter extremes.
- IDLE:
  - `tx_out`=1, `busy_out`=0.
  - On `send_in`=1, copy `data_in` into an internal shift/hold register, clear all counters, set `busy_out`=1, and go to START.
- START: `tx_out`=0 for `CLK_BAUD_RATIO` cycles, then go to DATA.
- DATA: `tx_out` = bit (frame_index·`FRAME_SIZE` + bit_index) of the latched word, held for `CLK_BAUD_RATIO` cycles per bit. After bit `FRAME_SIZE`-1, go to STOP.
- STOP: `tx_out`=1 for `CLK_BAUD_RATIO` cycles.
  - If frames remain, increment the frame index and go directly to START. There is no extra idle time between frames.
  - If this was the last frame, go to IDLE, clear `busy_out`, and pulse `done_out`.
- `data_in` is captured only at acceptance. Later changes to it have no effect on the word in flight.
- `send_in` is ignored while `busy_out`=1. Requests are not queued and not latched.
- Reset has priority over every other event, including a simultaneous `send_in` or a mid-frame abort:
  - Next cycle: `tx_out`=1, `busy_out`=0, `done_out`=0, state IDLE, all counters 0.
  - A partially sent frame is truncated. The line returns high immediately.
- All outputs are registered. `tx_out` has no combinational path from any input.

## Timing
- Let R = `CLK_BAUD_RATIO`, and let N = `FRAMES`·(`FRAME_SIZE`+2)·R.
- Request accepted at edge T (`send_in`=1, `busy_out`=0, `rst_in`=0):
  - Cycles T+1..T+R: `tx_out`=0 (start bit of frame 0).
  - Cycles T+1..T+N: `busy_out`=1.
  - Data bit k of frame f occupies cycles T+1+(f·(`FRAME_SIZE`+2)+1+k)·R through T+(f·(`FRAME_SIZE`+2)+2+k)·R.
  - Cycle T+N+1: `busy_out`=0 and `done_out`=1 for exactly this one cycle; `tx_out`=1.
- A `send_in` asserted in cycle T+N+1 is accepted. Its start bit begins at T+N+2, giving one idle-high cycle between words.
- Reset values: `tx_out`=1, `busy_out`=0, `done_out`=0.
- `done_out` never asserts after a reset-aborted transfer.

## Test plan
- **Basic word:** R=4, `FRAME_SIZE`=8, `FRAMES`=2. Reset, then pulse `send_in` with `data_in`=16'hA55A.
  - `tx_out` sequence per 4-cycle bit: 0, 0,1,0,1,1,0,1,0, 1, 0, 1,0,1,0,0,1,0,1, 1.
  - `busy_out` high for exactly 80 cycles; `done_out` is a single pulse at cycle 81.
- **Loopback:** `tx_out` wired to the multi-frame receiver, both with default parameters. Send 16'h0000, 16'hFFFF and 16'h1234 in turn.
  - Receiver returns each word unchanged.
  - No framing gap: frame-1 start bit immediately follows the frame-0 stop bit.
- **Ignored request:** assert `send_in` with 16'hBEEF mid-transfer of 16'h00FF.
  - Only 16'h00FF appears on the line; exactly one `done_out`.
  - Also change `data_in` after acceptance and check the transmitted bits are unaffected.
- **Back-to-back:** hold `send_in`=1 continuously with 16'h0102.
  - Words repeat with exactly one idle-high cycle between the last stop bit and the next start bit.
  - One `done_out` per word.
- **Reset mid-frame:** assert `rst_in` during data bit 3 of frame 1.
  - Next cycle: `tx_out`=1, `busy_out`=0, no `done_out`.
  - A subsequent `send_in` transmits correctly.
  - Reset asserted together with `send_in` results in no transfer.
- **Parameter corners:** R=1, `FRAME_SIZE`=1, `FRAMES`=1, `data_in`=1'b1.
  - `tx_out` = 0,1,1 over 3 cycles.
  - `busy_out` high for 3 cycles; `done_out` at cycle 4.

Source files
------------

// File: rtl/send_frames.sv
// send_frames: multi-frame UART transmitter.
//
// Accepts one DATA_SIZE-bit word on a single-cycle send_in request (while
// idle) and serialises it as FRAMES back-to-back UART frames, least
// significant frame first. Each frame is one start bit, FRAME_SIZE data bits
// LSB first, and one stop bit. Every bit lasts CLK_BAUD_RATIO clock cycles.
//
// Ports:
//   clk_in   - single clock, rising edge
//   rst_in   - synchronous active-high reset, highest priority
//   send_in  - transmit request, sampled only while busy_out is low
//   data_in  - word to send; [FRAME_SIZE-1:0] is frame 0
//   tx_out   - registered serial line, idle high
//   busy_out - registered, high while a word is on the line
//   done_out - registered one-cycle pulse after the final stop bit
module send_frames #(
    parameter int CLK_BAUD_RATIO = 25,
    parameter int FRAME_SIZE     = 8,
    parameter int FRAMES         = 2,
    localparam int DATA_SIZE     = FRAME_SIZE * FRAMES
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 send_in,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic                 tx_out,
    output logic                 busy_out,
    output logic                 done_out
);

    // Counter widths hold 0..max; a ratio/size of 1 still gets one bit so
    // no vector collapses to zero width.
    localparam int BAUD_W  = (CLK_BAUD_RATIO > 1) ? $clog2(CLK_BAUD_RATIO) : 1;
    localparam int BIT_W   = (FRAME_SIZE > 1)     ? $clog2(FRAME_SIZE)     : 1;
    localparam int FRAME_W = (FRAMES > 1)         ? $clog2(FRAMES)         : 1;

    localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLK_BAUD_RATIO - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(FRAME_SIZE - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [FRAME_W-1:0]     frame_q, frame_d;
    logic [DATA_SIZE-1:0]   word_q, word_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   baud_end_s;
    logic [DATA_SIZE-1:0]   word_shift_s;

    assign tx_out   = tx_q;
    assign busy_out = busy_q;
    assign done_out = done_q;

    // Next-state logic. The outputs are computed for the cycle after the
    // edge, so tx_d always reflects the bit the next state will drive. The
    // held word is shifted right once per data bit, so its LSB is always the
    // next data bit to send, across frame boundaries too.
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        frame_d      = frame_q;
        word_d       = word_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        baud_end_s   = (baud_q == BAUD_LAST);
        word_shift_s = word_q >> 1;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (send_in) begin
                    word_d  = data_in;
                    baud_d  = '0;
                    bit_d   = '0;
                    frame_d = '0;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_end_s) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = word_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    baud_d = '0;
                    word_d = word_shift_s;
                    if (bit_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        tx_d  = word_shift_s[0];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_end_s) begin
                    baud_d = '0;
                    if (frame_q == FRAME_LAST) begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // Next frame's start bit follows the stop bit directly.
                        frame_d = frame_q + FRAME_W'(1);
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset truncates any frame and idles the line.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            word_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            word_q  <= word_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule
